// File: rtl/keypad_emulator.sv
// keypad_emulator: replays queued key codes onto a row/column scanned keypad
// interface so a keypad scanner can be exercised without a physical keypad.
// A 4-entry FIFO buffers key codes; an FSM presses each key for HOLD_TICKS
// cycles, then releases it for GAP_TICKS cycles and pulses key_done.
// Optional feature macro: KEYEMU_BOUNCE_EN adds a contact-bounce phase of
// BOUNCE_TICKS cycles before each press.
module keypad_emulator #(
    parameter int HOLD_TICKS   = 40,
    parameter int GAP_TICKS    = 40,
    parameter int BOUNCE_TICKS = 6
) (
    input  logic       clk_500Hz,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] JC_rows,
    output logic [3:0] JC_cols,
    output logic       key_active,
    output logic       key_done,
    output logic       busy,
    output logic [2:0] fifo_count
);

    // Counter is sized for the longest phase so every terminal count fits.
    localparam int MAX_HB    = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int MAX_TICKS = (MAX_HB > BOUNCE_TICKS) ? MAX_HB : BOUNCE_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

`ifdef KEYEMU_BOUNCE_EN
    typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       cur_key_reg;
    logic             loaded_reg;
    logic             key_active_reg;
    logic             key_done_reg;

    logic [3:0]       fifo_mem [4];
    logic [1:0]       wr_ptr_reg;
    logic [1:0]       rd_ptr_reg;
    logic [2:0]       count_reg;

    logic             push;
    logic             pop;
    logic             is_pause;
    logic [3:0]       map_row;
    logic [3:0]       map_col;
    logic             map_hit;

    assign key_ready  = (count_reg < 3'd4);
    assign push       = key_valid && key_ready;
    // The head is taken once per key; loaded_reg marks the cycle between the
    // pop and the start of the press so a second pop cannot slip in.
    assign pop        = (state_reg == IDLE) && !loaded_reg && (count_reg != 3'd0);
    assign is_pause   = (cur_key_reg >= 4'd13);
    assign fifo_count = count_reg;
    assign key_active = key_active_reg;
    assign key_done   = key_done_reg;
    assign busy       = (state_reg != IDLE) || loaded_reg || (count_reg != 3'd0);

    // FIFO storage: written on accepted pushes, no reset needed on the data.
    always_ff @(posedge clk_500Hz) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= key_code;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Key sequencing FSM with registered key_active and key_done outputs.
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            cur_key_reg    <= 4'd0;
            loaded_reg     <= 1'b0;
            key_active_reg <= 1'b0;
            key_done_reg   <= 1'b0;
        end else begin
            key_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (loaded_reg) begin
                        loaded_reg     <= 1'b0;
                        cnt_reg        <= '0;
                        key_active_reg <= !is_pause;
`ifdef KEYEMU_BOUNCE_EN
                        state_reg      <= BOUNCE;
`else
                        state_reg      <= HOLD;
`endif
                    end else if (pop) begin
                        cur_key_reg <= fifo_mem[rd_ptr_reg];
                        loaded_reg  <= 1'b1;
                    end
                end
`ifdef KEYEMU_BOUNCE_EN
                BOUNCE: begin
                    if (cnt_reg == CNT_W'(BOUNCE_TICKS - 1)) begin
                        state_reg      <= HOLD;
                        cnt_reg        <= '0;
                        key_active_reg <= !is_pause;
                    end else begin
                        cnt_reg        <= cnt_reg + 1'b1;
                        key_active_reg <= !is_pause && !key_active_reg;
                    end
                end
`endif
                HOLD: begin
                    if (cnt_reg == CNT_W'(HOLD_TICKS - 1)) begin
                        state_reg      <= GAP;
                        cnt_reg        <= '0;
                        key_active_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == CNT_W'(GAP_TICKS - 1)) begin
                        state_reg    <= IDLE;
                        cnt_reg      <= '0;
                        key_done_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    cnt_reg        <= '0;
                    key_active_reg <= 1'b0;
                end
            endcase
        end
    end

    // Keypad matrix position of the current key (row required, column driven).
    always_comb begin
        map_row = 4'b1111;
        map_col = 4'b1111;
        map_hit = 1'b1;
        case (cur_key_reg)
            4'd1:  begin map_row = 4'b1110; map_col = 4'b1110; end
            4'd4:  begin map_row = 4'b1110; map_col = 4'b1101; end
            4'd7:  begin map_row = 4'b1110; map_col = 4'b1011; end
            4'd0:  begin map_row = 4'b1110; map_col = 4'b0111; end
            4'd2:  begin map_row = 4'b1101; map_col = 4'b1110; end
            4'd5:  begin map_row = 4'b1101; map_col = 4'b1101; end
            4'd8:  begin map_row = 4'b1101; map_col = 4'b1011; end
            4'd3:  begin map_row = 4'b1011; map_col = 4'b1110; end
            4'd6:  begin map_row = 4'b1011; map_col = 4'b1101; end
            4'd9:  begin map_row = 4'b1011; map_col = 4'b1011; end
            4'd11: begin map_row = 4'b1011; map_col = 4'b0111; end
            4'd10: begin map_row = 4'b0111; map_col = 4'b1011; end
            4'd12: begin map_row = 4'b0111; map_col = 4'b0111; end
            default: map_hit = 1'b0;
        endcase
    end

    // Column sense follows the scanner's row drive combinationally.
    assign JC_cols = (key_active_reg && map_hit && (JC_rows == map_row)) ? map_col : 4'b1111;

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_TICKS, default 40: key-pressed duration in clk_500Hz cycles; must exceed the scanner debounce of 20.
REQ-002 Parameter GAP_TICKS, default 40: released duration after each key, in cycles.
REQ-003 Parameter BOUNCE_TICKS, default 6: bounce-phase length in cycles; used only when KEYEMU_BOUNCE_EN is defined.
REQ-004 Port clk_500Hz, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port key_code, input, 4: key to press; 0-9 digits, 10 C (clear), 11 E (enter), 12 D (delete), 13-15 pause.
REQ-007 Port key_valid, input, 1: key_code is offered.
REQ-008 Port key_ready, output, 1: a key can be accepted.
REQ-009 Port JC_rows, input, 4: active-low row drive from the scanner.
REQ-010 Port JC_cols, output, 4: active-low column sense returned to the scanner.
REQ-011 Port key_active, output, 1: the current key is electrically pressed.
REQ-012 Port key_done, output, 1: one-cycle pulse at the end of each key's gap phase.
REQ-013 Port busy, output, 1: FSM is not IDLE or the FIFO is not empty.
REQ-014 Port fifo_count, output, 3: number of queued keys, 0-4.

Function
REQ-015 FIFO: 4 entries; key_ready = (fifo_count < 4); a key is pushed when key_valid && key_ready at a clock edge.
REQ-016 Push and pop in the same cycle leave fifo_count unchanged; pushes while full are ignored and lose no stored entry.
REQ-017 Key map, as (required JC_rows, driven JC_cols):
- 1 = (1110, 1110); 4 = (1110, 1101); 7 = (1110, 1011); 0 = (1110, 0111)
- 2 = (1101, 1110); 5 = (1101, 1101); 8 = (1101, 1011)
- 3 = (1011, 1110); 6 = (1011, 1101); 9 = (1011, 1011); E = (1011, 0111)
- C = (0111, 1011); D = (0111, 0111)
REQ-018 JC_cols is combinational: it equals the mapped column pattern when key_active = 1 and JC_rows exactly equals the required row; otherwise 4'b1111.
REQ-019 Pause codes 13-15 run the full timing sequence, keep key_active = 0, and hold JC_cols at 1111.
REQ-020 FSM states: IDLE, BOUNCE, HOLD, GAP; a single cycle counter is cleared on every state entry.
REQ-021 IDLE: when the FIFO is non-empty, pop the head into cur_key and go to BOUNCE if KEYEMU_BOUNCE_EN is defined, else to HOLD, on the next edge.
REQ-022 HOLD: key_active = 1 (0 for pause codes) for exactly HOLD_TICKS cycles, then go to GAP.
REQ-023 GAP: key_active = 0 for exactly GAP_TICKS cycles; on the last cycle pulse key_done for 1 cycle and go to IDLE.
REQ-024 Latency: from the push edge into an empty FIFO with the FSM in IDLE, key_active rises 2 edges later (no bounce).
REQ-025 Back-to-back keys: key_done and the next pop occur one IDLE cycle apart; keys are pressed strictly in FIFO order.
REQ-026 key_code is ignored while key_valid = 0; cur_key holds constant for the whole sequence of a key.

Reset
REQ-027 While rst_n = 0: FSM = IDLE, counter = 0, FIFO is emptied, fifo_count = 0, key_active = 0, key_done = 0, busy = 0, JC_cols = 1111, key_ready = 1.
REQ-028 Reset asserted mid-key aborts that key immediately, asynchronously; the key is not resumed after reset is released.

Configuration
REQ-029 Macro KEYEMU_BOUNCE_EN defined: the BOUNCE state lasts BOUNCE_TICKS cycles with key_active toggling every cycle, starting at 1, then goes to HOLD.
REQ-030 Macro KEYEMU_BOUNCE_EN undefined: the BOUNCE state and BOUNCE_TICKS logic are absent, and IDLE goes directly to HOLD.

Verification
REQ-031 Push key 5; scanner drives JC_rows = 1101 -> JC_cols = 1101 for 40 cycles, then 1111; key_done pulses once after a further 40 cycles.
REQ-032 Push E with JC_rows cycling 1110/1101/1011/0111 -> JC_cols = 0111 only while JC_rows = 1011 during HOLD.
REQ-033 Push 1, 2, 3, 4 on consecutive cycles, then offer 9 -> fifo_count reaches 4, key_ready = 0, 9 is not accepted, and keys are pressed in order 1, 2, 3, 4.
REQ-034 Push 15 -> JC_cols stays 1111 and key_active stays 0 throughout; key_done pulses 81 cycles after the pop.
REQ-035 Assert rst_n = 0 in cycle 10 of HOLD for key 7 with JC_rows = 1110 -> JC_cols = 1111 immediately, fifo_count = 0, and no key_done pulse.
REQ-036 With KEYEMU_BOUNCE_EN defined, push 0 with JC_rows = 1110 -> JC_cols alternates 0111/1111 for 6 cycles, then holds 0111 for 40 cycles.
